core_sram_bridge: RTL and testbench

Slave endpoint for the core data/instruction request channel (req/gnt/rvalid). Accepts granted core transactions, forwards them to a single-port synchronous SRAM with fixed read latency, and returns one in-order response per granted request. It tracks outstanding transactions and flags accesses outside its address window with an error response. It sits directly downstream of the core interface and is the default memory model and target for the core testbench.

---
 rtl/core_sram_bridge.sv | 112 +++++++++++
 tb/tb_core_sram_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sram_bridge.sv
// -----------------------------------------------------------------------------
// core_sram_bridge
//
// Slave endpoint for the core req/gnt/rvalid channel. Granted requests inside
// the address window are forwarded to a single-port synchronous SRAM with a
// fixed read latency; requests outside the window are granted locally and
// answered with an error. Exactly one response is returned per grant, strictly
// in grant order, MEM_LATENCY cycles after the grant.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req/addr/we/be/wdata   core request (held stable by the core until gnt)
//   gnt               request accepted this cycle (combinational)
//   rvalid/rdata/err  in-order response; rdata is 0 for writes and errors
//   mem_req/mem_gnt   SRAM strobe and SRAM arbiter grant
//   mem_addr/mem_we/mem_be/mem_wdata   combinational copies of the request
//   mem_rdata         SRAM read data, MEM_LATENCY cycles after a read strobe
// -----------------------------------------------------------------------------
module core_sram_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MEM_AW          = 12,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  // Clears the in-window offset bits; what remains must equal the base.
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK =
    ~((ADDR_WIDTH'(1) << (MEM_AW + 2)) - ADDR_WIDTH'(1));

  typedef struct packed {
    logic valid;
    logic is_read;
    logic err;
  } resp_t;

  resp_t            pipe [MEM_LATENCY];
  resp_t            last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             in_win;
  logic             room;

  assign last   = pipe[MEM_LATENCY-1];
  assign in_win = (addr & WIN_MASK) == ADDR_BASE;
  // A response leaving this cycle frees its slot for a grant in the same cycle.
  assign room   = (cnt < MAX_CNT) || last.valid;

  // Reset gates the handshake outputs so nothing is accepted while held.
  assign gnt     = rst & req & room & (mem_gnt | ~in_win);
  assign mem_req = rst & req & room & in_win;

  assign mem_addr  = addr[MEM_AW+1:2];
  assign mem_we    = we;
  assign mem_be    = be;
  assign mem_wdata = wdata;

  assign rvalid = last.valid;
  assign err    = last.valid & last.err;
  assign rdata  = (last.valid && last.is_read && !last.err) ? mem_rdata : '0;

  // Response pipeline: stage 0 captures each grant, stages shift every cycle
  // so the final stage lines up with the SRAM read data.
  // NOTE: the pipeline is only a few flops, so every field is reset, not just
  // the valid bits; sequential state is always assigned with <= so all stages
  // see the pre-edge values of their neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: gnt, is_read: ~we, err: ~in_win};
      for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // NOTE: cnt_next gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cnt_next = cnt;
    if (gnt && !last.valid)      cnt_next = cnt + CNT_W'(1);
    else if (!gnt && last.valid) cnt_next = cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_next;
  end

endmodule

// File: tb/tb_core_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_core_sram_bridge
//
// Three bridge instances with different latency / outstanding limits:
//   inst 0: MEM_LATENCY=1, MAX_OUTSTANDING=2
//   inst 1: MEM_LATENCY=2, MAX_OUTSTANDING=3
//   inst 2: MEM_LATENCY=3, MAX_OUTSTANDING=2
// Each has its own SRAM model and a per-cycle reference model (expected
// response queue plus a memory image) that checks every output.
// -----------------------------------------------------------------------------
module tb_core_sram_bridge;

  localparam int N         = 3;
  localparam int WIN_BYTES = 4 * 4096;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s      [N];
  logic        req_s      [N];
  logic [31:0] addr_s     [N];
  logic        we_s       [N];
  logic [3:0]  be_s       [N];
  logic [31:0] wdata_s    [N];
  logic        gnt_s      [N];
  logic        rvalid_s   [N];
  logic [31:0] rdata_s    [N];
  logic        err_s      [N];
  logic        mem_req_s  [N];
  logic        mem_gnt_s  [N];
  logic [11:0] mem_addr_s [N];
  logic        mem_we_s   [N];
  logic [3:0]  mem_be_s   [N];
  logic [31:0] mem_wdata_s[N];
  logic [31:0] mem_rdata_s[N];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int LAT = g + 1;
    localparam int MO  = (g == 1) ? 3 : 2;

    core_sram_bridge #(.MEM_LATENCY(LAT), .MAX_OUTSTANDING(MO)) u_dut (
      .clk(clk), .rst(rst_s[g]), .req(req_s[g]), .addr(addr_s[g]), .we(we_s[g]),
      .be(be_s[g]), .wdata(wdata_s[g]), .gnt(gnt_s[g]), .rvalid(rvalid_s[g]),
      .rdata(rdata_s[g]), .err(err_s[g]), .mem_req(mem_req_s[g]),
      .mem_gnt(mem_gnt_s[g]), .mem_addr(mem_addr_s[g]), .mem_we(mem_we_s[g]),
      .mem_be(mem_be_s[g]), .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g])
    );

    // SRAM environment model: fixed read latency, garbage on non-read cycles.
    logic [31:0] sram  [4096];
    logic [31:0] rpipe [4];
    initial for (int i = 0; i < 4096; i++) sram[i] = '0;
    always @(posedge clk) begin
      rpipe[0] <= 32'h5A5A_5A5A;
      if (mem_req_s[g] && mem_gnt_s[g]) begin
        if (mem_we_s[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be_s[g][b]) sram[mem_addr_s[g]][8*b +: 8] <= mem_wdata_s[g][8*b +: 8];
        end else begin
          rpipe[0] <= sram[mem_addr_s[g]];
        end
      end
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata_s[g] = rpipe[LAT-1];

    // Reference model: a queue of expected responses stamped with their due
    // cycle, and a memory image updated in grant order.
    exp_t        q [$];
    logic [31:0] ref_mem [4096];
    int          cyc = 0;
    initial for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

    always @(negedge clk) begin
      logic        exp_rv, iw, has_room, exp_gnt, exp_mreq;
      int          idx;
      exp_t        e;
      cyc++;
      if (!rst_s[g]) begin
        check($sformatf("i%0d_rst_gnt", g), 32'(gnt_s[g]), 0);
        check($sformatf("i%0d_rst_mem_req", g), 32'(mem_req_s[g]), 0);
        check($sformatf("i%0d_rst_rvalid", g), 32'(rvalid_s[g]), 0);
        check($sformatf("i%0d_rst_err", g), 32'(err_s[g]), 0);
        check($sformatf("i%0d_rst_rdata", g), rdata_s[g], 0);
        q.delete();
      end else begin
        exp_rv = (q.size() > 0) && (q[0].due == cyc);
        check($sformatf("i%0d_rvalid@%0d", g, cyc), 32'(rvalid_s[g]), 32'(exp_rv));
        if (exp_rv) begin
          e = q.pop_front();
          check($sformatf("i%0d_err@%0d", g, cyc), 32'(err_s[g]), 32'(e.err));
          check($sformatf("i%0d_rdata@%0d", g, cyc), rdata_s[g], e.data);
        end
        iw       = (addr_s[g] >= BASE) && (addr_s[g] < BASE + WIN_BYTES);
        has_room = q.size() < MO;
        exp_gnt  = req_s[g] && has_room && (mem_gnt_s[g] || !iw);
        exp_mreq = req_s[g] && has_room && iw;
        idx      = int'((addr_s[g] - BASE) / 4);
        check($sformatf("i%0d_gnt@%0d", g, cyc), 32'(gnt_s[g]), 32'(exp_gnt));
        check($sformatf("i%0d_mem_req@%0d", g, cyc), 32'(mem_req_s[g]), 32'(exp_mreq));
        if (exp_mreq) begin
          check($sformatf("i%0d_mem_addr", g), 32'(mem_addr_s[g]), 32'(idx));
          check($sformatf("i%0d_mem_we", g), 32'(mem_we_s[g]), 32'(we_s[g]));
          check($sformatf("i%0d_mem_be", g), 32'(mem_be_s[g]), 32'(be_s[g]));
          check($sformatf("i%0d_mem_wdata", g), mem_wdata_s[g], wdata_s[g]);
        end
        if (exp_gnt) begin
          if (iw && we_s[g])
            for (int b = 0; b < 4; b++)
              if (be_s[g][b]) ref_mem[idx][8*b +: 8] = wdata_s[g][8*b +: 8];
          e.due     = cyc + LAT;
          e.is_read = !we_s[g];
          e.err     = !iw;
          e.data    = (!we_s[g] && iw) ? ref_mem[idx] : 32'h0;
          q.push_back(e);
        end
      end
    end
  end

  // One complete transaction on instance k; returns response and latency.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(posedge clk); #1;
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; be_s[k] = b; wdata_s[k] = d;
    n = 0;
    @(negedge clk);
    while (!gnt_s[k] && n < 20) begin @(negedge clk); n++; end
    if (!gnt_s[k]) check($sformatf("i%0d_gnt_timeout", k), 0, 1);
    @(posedge clk); #1;
    req_s[k] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rvalid_s[k] && lat < 20) begin @(negedge clk); lat++; end
    rd = rdata_s[k];
    e  = err_s[k];
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [10];
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          rv_cyc [$];
    logic [31:0] rv_dat [$];
    bit          granted [N];

    vt[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vt[1] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF,  1'b0};
    vt[2] = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0,          1'b0};
    vt[3] = '{1'b1, 32'h0000_0020, 4'h5, 32'hAAAA_AAAA, 32'h0,          1'b0};
    vt[4] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h11AA_33AA,  1'b0};
    vt[5] = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,         32'h0,          1'b1};
    vt[6] = '{1'b1, 32'h0000_4004, 4'hF, 32'h0000_1234, 32'h0,          1'b1};
    vt[7] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D, 32'h0,          1'b0};
    vt[8] = '{1'b0, 32'h0000_3FFE, 4'hF, 32'h0,         32'hCAFE_F00D,  1'b0};
    vt[9] = '{1'b0, 32'h0001_0010, 4'hF, 32'h0,         32'h0,          1'b1};

    for (int k = 0; k < N; k++) begin
      rst_s[k] = 1'b0; req_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = 32'h10;
      be_s[k] = 4'hF; wdata_s[k] = '0; mem_gnt_s[k] = 1'b1;
    end
    // Reset state, with requests asserted to show gnt/mem_req are gated.
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("i%0d_reset_gnt", k), 32'(gnt_s[k]), 0);
      check($sformatf("i%0d_reset_rvalid", k), 32'(rvalid_s[k]), 0);
      check($sformatf("i%0d_reset_rdata", k), rdata_s[k], 0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin req_s[k] = 1'b0; rst_s[k] = 1'b1; end

    // Table-driven transactions on instance 0 (latency 1).
    for (int i = 0; i < 10; i++) begin
      do_txn(0, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, rd, e, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(lat_of(0)));
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
    end

    // SRAM arbiter withholds grant for 3 cycles on a pending read.
    @(posedge clk); #1;
    mem_gnt_s[0] = 1'b0; req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_gnt", i), 32'(gnt_s[0]), 0);
      check($sformatf("stall%0d_mem_req", i), 32'(mem_req_s[0]), 1);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1; mem_gnt_s[0] = 1'b1;
    @(negedge clk); check("stall_release_gnt", 32'(gnt_s[0]), 1);
    @(posedge clk); #1; req_s[0] = 1'b0;
    @(negedge clk);
    check("stall_rvalid", 32'(rvalid_s[0]), 1);
    check("stall_rdata", rdata_s[0], 32'hDEAD_BEEF);

    // Out-of-window read is granted even with the SRAM unavailable.
    @(posedge clk); #1;
    mem_gnt_s[0] = 1'b0; req_s[0] = 1'b1; addr_s[0] = BASE + WIN_BYTES;
    @(negedge clk);
    check("oow_gnt", 32'(gnt_s[0]), 1);
    check("oow_mem_req", 32'(mem_req_s[0]), 0);
    @(posedge clk); #1; req_s[0] = 1'b0;
    @(negedge clk);
    check("oow_rvalid", 32'(rvalid_s[0]), 1);
    check("oow_err", 32'(err_s[0]), 1);
    check("oow_rdata", rdata_s[0], 0);
    @(posedge clk); #1; mem_gnt_s[0] = 1'b1;

    // Streaming on instance 1 (latency 2, 3 outstanding).
    for (int i = 0; i < 8; i++)
      do_txn(1, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i), rd, e, lat);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_s[1] = (c < 8); we_s[1] = 1'b0; addr_s[1] = 32'h100 + 32'(4*c);
      @(negedge clk);
      if (c < 8) check($sformatf("stream_gnt%0d", c), 32'(gnt_s[1]), 1);
      if (rvalid_s[1]) begin rv_cyc.push_back(c); rv_dat.push_back(rdata_s[1]); end
    end
    check("stream_resp_count", 32'(rv_cyc.size()), 8);
    for (int i = 0; i < rv_cyc.size() && i < 8; i++) begin
      check($sformatf("stream_resp%0d_cycle", i), 32'(rv_cyc[i]), 32'(i + lat_of(1)));
      check($sformatf("stream_resp%0d_data", i), rv_dat[i], 32'hC0DE_0000 + 32'(i));
    end

    // Outstanding limit on instance 2 (latency 3, 2 outstanding).
    @(posedge clk); #1;
    req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("limit_gnt%0d", i), 32'(gnt_s[2]), 32'(i % 3 != 2));
      @(posedge clk); #1;
    end
    req_s[2] = 1'b0;
    repeat (6) @(posedge clk);

    // Reset with two reads in flight on instance 1.
    @(posedge clk); #1; req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h100;
    @(negedge clk);
    @(posedge clk); #1; addr_s[1] = 32'h104;
    @(negedge clk);
    @(posedge clk); #1; req_s[1] = 1'b0;
    check("mid_rst_pre_rvalid", 32'(rvalid_s[1]), 1);
    rst_s[1] = 1'b0; req_s[1] = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid_s[1]), 0);
    check("mid_rst_gnt", 32'(gnt_s[1]), 0);
    req_s[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_s[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_rvalid%0d", i), 32'(rvalid_s[1]), 0);
    end
    do_txn(1, 1'b0, 32'h104, 4'hF, 32'h0, rd, e, lat);
    check("post_rst_latency", 32'(lat), 32'(lat_of(1)));
    check("post_rst_rdata", rd, 32'hC0DE_0001);

    // Randomized traffic on all instances, checked by the reference models.
    for (int k = 0; k < N; k++) granted[k] = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (!req_s[k] || granted[k]) begin
          req_s[k]   = ($urandom_range(3) != 0);
          we_s[k]    = 1'($urandom_range(1));
          be_s[k]    = 4'($urandom_range(15));
          wdata_s[k] = $urandom;
          if ($urandom_range(7) == 0)
            addr_s[k] = ($urandom_range(1) != 0) ? 32'h8000_0000 + 32'($urandom_range(255))
                                                 : BASE + WIN_BYTES + 32'($urandom_range(1023));
          else
            addr_s[k] = BASE + 32'($urandom_range(63) * 4 + $urandom_range(3));
        end
        mem_gnt_s[k] = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) granted[k] = gnt_s[k];
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin req_s[k] = 1'b0; mem_gnt_s[k] = 1'b1; end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("drain_i0", 32'(g_inst[0].q.size()), 0);
    check("drain_i1", 32'(g_inst[1].q.size()), 0);
    check("drain_i2", 32'(g_inst[2].q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
